instr_fetch_mp: RTL and testbench
=================================

Name: instr_fetch_mp

Overview:
- Parametrised multi-port instruction memory: the next generation of the dual-read instruction cache.
- One write port, NUM_RD independent read ports, configurable depth and widths.
- Each read port has a req/gnt request handshake and a valid/ack response handshake, with a one-entry output holding register, so fetch stages can stall without losing data.
- Out-of-range addresses return an error flag instead of aliasing.

Parameters:
- ADDR_WIDTH, 32, width of every address port (word address).
- DATA_WIDTH, 32, instruction word width.
- DEPTH_LOG2, 10, log2 of memory depth in words (default 1024 words).
- NUM_RD, 2, number of read ports (1..8).

Ports:
- clk  input  1  clock, all logic on posedge
- rst  input  1  synchronous active-high reset
- wr_en  input  1  write strobe
- wr_addr  input  ADDR_WIDTH  write word address
- wr_data  input  DATA_WIDTH  write data
- wr_err  output  1  registered: last write address was out of range
- rd_req  input  NUM_RD  per-port read request
- rd_addr  input  NUM_RD*ADDR_WIDTH  per-port address; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- rd_gnt  output  NUM_RD  combinational: request accepted this cycle
- rd_valid  output  NUM_RD  registered: holding register has data
- rd_data  output  NUM_RD*DATA_WIDTH  per-port read data, same slicing as rd_addr
- rd_err  output  NUM_RD  per-port: held word came from an out-of-range address
- rd_ack  input  NUM_RD  per-port: consumer takes held word this cycle

Behaviour:
- Reset (rst=1 at posedge): rd_valid=0, rd_data=0, rd_err=0, wr_err=0. Memory contents are not reset. Reset mid-transaction discards held words; no gnt is honoured in the reset cycle.
- Address map: index = addr[DEPTH_LOG2-1:0]. An address is in range iff addr[ADDR_WIDTH-1:DEPTH_LOG2]==0.
- Write: on posedge with wr_en=1 and in range, mem[index] <= wr_data and wr_err <= 0. Out of range: no write, wr_err <= 1. wr_err holds until the next write.
- Per-port state: EMPTY (rd_valid=0) or FULL (rd_valid=1).
- Grant: rd_gnt[i] = rd_req[i] & ~rst & (~rd_valid[i] | rd_ack[i]) & ~wr_en. The wr_en term is removed under the optional feature.
- Latency: a grant in cycle N gives rd_valid=1 with data in cycle N+1.
- Read result: in range -> rd_data = mem[index], rd_err=0. Out of range -> rd_data=0, rd_err=1.
- FULL with rd_ack=0: rd_data and rd_err held stable; rd_gnt=0 (backpressure).
- FULL with rd_ack=1 and new grant: next word loaded; rd_valid stays 1 (back-to-back, one word per cycle).
- FULL with rd_ack=1 and no grant: rd_valid <= 0; rd_data holds its last value.
- rd_ack while EMPTY: ignored.
- Ports are fully independent; any number may read the same address in the same cycle.
- Write priority (feature off): wr_en=1 suppresses every rd_gnt that cycle. Held words are unaffected. A read granted the cycle after a write sees the new data.

Optional Feature:
- Macro: INSTR_FETCH_MP_WR_FWD_EN
- Defined: wr_en does not block grants. A read granted in the same cycle as an in-range write to the same index returns wr_data (write-first forwarding). Different index returns the old mem contents.
- Undefined: grants are blocked while wr_en=1, as above.

Test Plan:
- Write 0x00000013 to addr 5, then port0 req addr 5 -> gnt same cycle; next cycle rd_valid[0]=1, rd_data0=0x00000013, rd_err[0]=0.
- Port1 req addr 0x400 (DEPTH_LOG2=10) -> rd_valid[1]=1, rd_data1=0, rd_err[1]=1. Write to 0x400 -> wr_err=1, mem[0] unchanged.
- Port0 FULL, rd_ack=0 for 3 cycles with req held on a new addr -> rd_gnt[0]=0 and data stable for 3 cycles. Ack with req on addr 6 (holding 0xABCD0000) -> next cycle rd_data0=0xABCD0000 with rd_valid held 1.
- Both ports req addr 7 while wr_en=1 writes 0x11 to addr 7:
  - Feature off: rd_gnt=00; next-cycle grant returns 0x11.
  - Feature on: rd_gnt=11; both return 0x11.
- Assert rst while both ports are FULL -> next cycle rd_valid=00, rd_data=0, rd_err=00. mem[5] still reads 0x00000013 afterwards.
- Port0 streams addrs 0..15 with rd_ack=1 every cycle -> 16 consecutive valid cycles, one word per cycle, data matching the preloaded pattern.

Source files
------------

// File: rtl/instr_fetch_mp.sv
// instr_fetch_mp: multi-port instruction memory with one write port and NUM_RD
// independent read ports. Each read port has a req/gnt request handshake and a
// one-entry holding register drained through a valid/ack handshake, so a
// stalled fetch stage never loses a word. Out-of-range addresses never alias:
// reads return zero with rd_err set, and writes are dropped with wr_err set.
// Optional macro INSTR_FETCH_MP_WR_FWD_EN: when defined, writes no longer block
// read grants, and a read of the index being written in the same cycle returns
// the incoming write data (write-first forwarding).
module instr_fetch_mp #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int NUM_RD     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  output logic                           wr_err,
  input  logic [NUM_RD-1:0]              rd_req,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_RD-1:0]              rd_gnt,
  output logic [NUM_RD-1:0]              rd_valid,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_RD-1:0]              rd_err,
  input  logic [NUM_RD-1:0]              rd_ack
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} port_state_e;

  logic [DATA_WIDTH-1:0]        mem [DEPTH];
  port_state_e                  state_p1  [NUM_RD];
  port_state_e                  state_nxt [NUM_RD];
  logic [NUM_RD-1:0]            vld_p1;
  logic [NUM_RD*DATA_WIDTH-1:0] data_p1;
  logic [NUM_RD-1:0]            err_p1;
  logic [NUM_RD*DATA_WIDTH-1:0] fetch_word;
  logic [NUM_RD-1:0]            fetch_oor;
  logic                         wr_err_p1;

  // An address is legal only when every bit above the index field is zero.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >> DEPTH_LOG2) == '0;
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] addr_index(input logic [ADDR_WIDTH-1:0] addr);
    return addr[DEPTH_LOG2-1:0];
  endfunction

  // Grant when requested, out of reset, and the holding register is free or being drained.
  always_comb begin
    rd_gnt = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_gnt[i] = rd_req[i] & ~rst & (~vld_p1[i] | rd_ack[i]);
    end
`ifndef INSTR_FETCH_MP_WR_FWD_EN
    if (wr_en) rd_gnt = '0;
`endif
  end

  // Word each port would capture if granted now; out-of-range reads yield zero.
  always_comb begin
    fetch_word = '0;
    fetch_oor  = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (!addr_in_range(rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        fetch_oor[i] = 1'b1;
      end else begin
`ifdef INSTR_FETCH_MP_WR_FWD_EN
        if (wr_en && addr_in_range(wr_addr) &&
            addr_index(wr_addr) == addr_index(rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
          fetch_word[i*DATA_WIDTH +: DATA_WIDTH] = wr_data;
        end else begin
          fetch_word[i*DATA_WIDTH +: DATA_WIDTH] =
            mem[addr_index(rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH])];
        end
`else
        fetch_word[i*DATA_WIDTH +: DATA_WIDTH] =
          mem[addr_index(rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH])];
`endif
      end
    end
  end

  // Per-port EMPTY/FULL state register.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_RD; i++) begin
      if (rst) state_p1[i] <= EMPTY;
      else     state_p1[i] <= state_nxt[i];
    end
  end

  // Next state: a grant always fills, an ack without a grant empties, otherwise hold.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      state_nxt[i] = state_p1[i];
      vld_p1[i]    = (state_p1[i] == FULL);
      case (state_p1[i])
        EMPTY:   if (rd_gnt[i]) state_nxt[i] = FULL;
        FULL:    if (rd_gnt[i]) state_nxt[i] = FULL;
                 else if (rd_ack[i]) state_nxt[i] = EMPTY;
        default: state_nxt[i] = EMPTY;
      endcase
    end
  end

  // ---- stage p1: holding registers, loaded only on grant so stalls keep data stable ----
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1 <= '0;
      err_p1  <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (rd_gnt[i]) begin
          data_p1[i*DATA_WIDTH +: DATA_WIDTH] <= fetch_word[i*DATA_WIDTH +: DATA_WIDTH];
          err_p1[i]                           <= fetch_oor[i];
        end
      end
    end
  end

  // Memory array write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && addr_in_range(wr_addr)) begin
      mem[addr_index(wr_addr)] <= wr_data;
    end
  end

  // Write error flag tracks the most recent write attempt.
  always_ff @(posedge clk) begin
    if (rst)        wr_err_p1 <= 1'b0;
    else if (wr_en) wr_err_p1 <= ~addr_in_range(wr_addr);
  end

  assign wr_err   = wr_err_p1;
  assign rd_valid = vld_p1;
  assign rd_data  = data_p1;
  assign rd_err   = err_p1;

endmodule

// File: tb/tb_instr_fetch_mp.sv
// tb_instr_fetch_mp: scenario tasks plus randomized traffic, compared cycle by
// cycle against a behavioural model (array memory + per-port held word).
module tb_instr_fetch_mp;
  localparam int AW = 32, DW = 32, DL = 10, NR = 2, DEPTH = 1 << DL;

  logic clk = 1'b0;
  logic rst, wr_en, wr_err;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [NR-1:0] rd_req, rd_gnt, rd_valid, rd_err, rd_ack;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;

  int n_vec = 0, n_err = 0;

  // Reference model state
  logic [DW-1:0]    m_mem [DEPTH];
  logic [NR-1:0]    m_vld, m_err;
  logic [NR*DW-1:0] m_data;
  logic             m_wr_err;

  always #5 clk = ~clk;

  instr_fetch_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(DL), .NUM_RD(NR)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_err(wr_err), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err), .rd_ack(rd_ack)
  );

  function automatic bit in_rng(logic [AW-1:0] a);
    return a < AW'(DEPTH);
  endfunction

  function automatic logic [NR-1:0] model_gnt();
    logic [NR-1:0] g;
    for (int i = 0; i < NR; i++) g[i] = rd_req[i] && !rst && (!m_vld[i] || rd_ack[i]);
`ifndef INSTR_FETCH_MP_WR_FWD_EN
    if (wr_en) g = '0;
`endif
    return g;
  endfunction

  // One clock: model evaluates the current inputs, then outputs settle.
  task automatic adv();
    logic [NR-1:0] g;
    logic [AW-1:0] a;
    g = model_gnt();
    @(posedge clk);
    if (rst) begin
      m_vld = '0; m_err = '0; m_data = '0; m_wr_err = 1'b0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        a = rd_addr[i*AW +: AW];
        if (g[i]) begin
          m_vld[i] = 1'b1;
          m_err[i] = !in_rng(a);
          if (!in_rng(a))                                 m_data[i*DW +: DW] = '0;
          else if (wr_en && in_rng(wr_addr) && wr_addr == a) m_data[i*DW +: DW] = wr_data;
          else                                            m_data[i*DW +: DW] = m_mem[a[DL-1:0]];
        end else if (rd_ack[i]) begin
          m_vld[i] = 1'b0;
        end
      end
      if (wr_en) begin
        if (in_rng(wr_addr)) m_mem[wr_addr[DL-1:0]] = wr_data;
        m_wr_err = !in_rng(wr_addr);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; rd_req = '1; rd_ack = '0; rd_addr = '0;
    wr_addr = '0; wr_data = '0;
    #1;
    n_vec++;
    if (rd_gnt !== '0) begin
      n_err++; $display("FAIL reset_gnt got %b want 00", rd_gnt);
    end
    adv(); adv();
    n_vec++;
    if ({rd_valid, rd_err, wr_err, rd_data} !== '0) begin
      n_err++; $display("FAIL reset_state got v=%b e=%b we=%b d=%h want all zero",
                        rd_valid, rd_err, wr_err, rd_data);
    end
    rst = 1'b0; rd_req = '0;
  endtask

  task automatic test_preload();
    logic [NR-1:0] g;
    for (int a = 0; a < DEPTH; a++) begin
      wr_en = 1'b1; wr_addr = AW'(a);
      wr_data = (a == 5) ? 32'h0000_0013 : (a == 6) ? 32'hABCD_0000 : $urandom;
      rd_req = NR'($urandom); rd_ack = NR'($urandom);
      for (int p = 0; p < NR; p++) rd_addr[p*AW +: AW] = AW'($urandom_range(a, 0));
      #1;
      g = model_gnt();
      n_vec++;
      if (rd_gnt !== g) begin
        n_err++; $display("FAIL preload_gnt a=%0d got %b want %b", a, rd_gnt, g);
      end
      adv();
      n_vec++;
      if ({rd_valid, rd_err, wr_err, rd_data} !== {m_vld, m_err, m_wr_err, m_data}) begin
        n_err++; $display("FAIL preload_state a=%0d got %h want %h", a,
                          {rd_valid, rd_err, wr_err, rd_data}, {m_vld, m_err, m_wr_err, m_data});
      end
    end
    wr_en = 1'b0; rd_req = '0; rd_ack = '1;
    adv();
    rd_ack = '0;
  endtask

  task automatic test_read_range();
    rd_req = 2'b01; rd_addr[0 +: AW] = 32'd5; rd_ack = '0;
    #1;
    n_vec++;
    if (rd_gnt !== 2'b01) begin n_err++; $display("FAIL rd5_gnt got %b want 01", rd_gnt); end
    adv();
    n_vec++;
    if (rd_valid[0] !== 1'b1 || rd_data[0 +: DW] !== 32'h13 || rd_err[0] !== 1'b0) begin
      n_err++; $display("FAIL rd5_data got v=%b d=%h e=%b want 1 00000013 0",
                        rd_valid[0], rd_data[0 +: DW], rd_err[0]);
    end
    rd_req = 2'b10; rd_ack = 2'b01; rd_addr[AW +: AW] = 32'h400;
    #1;
    n_vec++;
    if (rd_gnt !== 2'b10) begin n_err++; $display("FAIL oor_gnt got %b want 10", rd_gnt); end
    adv();
    n_vec++;
    if (rd_valid !== 2'b10 || rd_data[DW +: DW] !== '0 || rd_err[1] !== 1'b1) begin
      n_err++; $display("FAIL oor_read got v=%b d1=%h e=%b want 10 0 e1=1",
                        rd_valid, rd_data[DW +: DW], rd_err);
    end
    rd_req = '0; rd_ack = '1; wr_en = 1'b1; wr_addr = 32'h400; wr_data = $urandom;
    adv();
    n_vec++;
    if (wr_err !== 1'b1 || rd_valid !== 2'b00) begin
      n_err++; $display("FAIL oor_write got wr_err=%b v=%b want 1 00", wr_err, rd_valid);
    end
    wr_en = 1'b0; rd_ack = '0; rd_req = 2'b01; rd_addr[0 +: AW] = 32'd0;
    adv();
    n_vec++;
    if (rd_data[0 +: DW] !== m_mem[0] || rd_valid[0] !== 1'b1) begin
      n_err++; $display("FAIL mem0_kept got %h want %h", rd_data[0 +: DW], m_mem[0]);
    end
    rd_req = '0; rd_ack = '1; wr_en = 1'b1; wr_addr = 32'd5; wr_data = 32'h13;
    adv();
    n_vec++;
    if (wr_err !== 1'b0) begin n_err++; $display("FAIL wr_err_clear got %b want 0", wr_err); end
    wr_en = 1'b0; rd_ack = '0;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held;
    rd_req = 2'b01; rd_addr[0 +: AW] = 32'd9; rd_ack = '0;
    adv();
    held = rd_data[0 +: DW];
    n_vec++;
    if (held !== m_mem[9]) begin n_err++; $display("FAIL bp_load got %h want %h", held, m_mem[9]); end
    rd_addr[0 +: AW] = 32'd10;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++;
      if (rd_gnt[0] !== 1'b0) begin n_err++; $display("FAIL bp_gnt k=%0d got %b want 0", k, rd_gnt[0]); end
      adv();
      n_vec++;
      if (rd_valid[0] !== 1'b1 || rd_data[0 +: DW] !== held) begin
        n_err++; $display("FAIL bp_hold k=%0d got v=%b d=%h want 1 %h", k, rd_valid[0], rd_data[0 +: DW], held);
      end
    end
    rd_ack = 2'b01; rd_addr[0 +: AW] = 32'd6;
    #1;
    n_vec++;
    if (rd_gnt[0] !== 1'b1) begin n_err++; $display("FAIL b2b_gnt got %b want 1", rd_gnt[0]); end
    adv();
    n_vec++;
    if (rd_valid[0] !== 1'b1 || rd_data[0 +: DW] !== 32'hABCD_0000) begin
      n_err++; $display("FAIL b2b_data got v=%b d=%h want 1 abcd0000", rd_valid[0], rd_data[0 +: DW]);
    end
    rd_req = '0;
    adv();
    n_vec++;
    if (rd_valid[0] !== 1'b0 || rd_data[0 +: DW] !== 32'hABCD_0000) begin
      n_err++; $display("FAIL drain_hold got v=%b d=%h want 0 abcd0000", rd_valid[0], rd_data[0 +: DW]);
    end
    rd_ack = '0;
  endtask

  task automatic test_wr_collision();
    rd_req = 2'b11; rd_addr = {32'd7, 32'd7}; rd_ack = '0;
    wr_en = 1'b1; wr_addr = 32'd7; wr_data = 32'h11;
    #1;
    n_vec++;
`ifdef INSTR_FETCH_MP_WR_FWD_EN
    if (rd_gnt !== 2'b11) begin n_err++; $display("FAIL coll_gnt got %b want 11", rd_gnt); end
`else
    if (rd_gnt !== 2'b00) begin n_err++; $display("FAIL coll_gnt got %b want 00", rd_gnt); end
`endif
    adv();
    n_vec++;
    if ({rd_valid, rd_err, rd_data} !== {m_vld, m_err, m_data}) begin
      n_err++; $display("FAIL coll_state got %h want %h", {rd_valid, rd_err, rd_data}, {m_vld, m_err, m_data});
    end
    wr_en = 1'b0; rd_ack = '1;
    #1;
    n_vec++;
    if (rd_gnt !== 2'b11) begin n_err++; $display("FAIL coll_next_gnt got %b want 11", rd_gnt); end
    adv();
    n_vec++;
    if (rd_valid !== 2'b11 || rd_data !== {32'h11, 32'h11} || rd_err !== 2'b00) begin
      n_err++; $display("FAIL coll_next_data got v=%b d=%h want 11 0000001100000011", rd_valid, rd_data);
    end
    rd_ack = '0;
  endtask

  task automatic test_reset_full();
    rst = 1'b1; rd_req = 2'b11; rd_addr = {32'd1, 32'd2};
    #1;
    n_vec++;
    if (rd_gnt !== 2'b00) begin n_err++; $display("FAIL rstfull_gnt got %b want 00", rd_gnt); end
    adv();
    n_vec++;
    if ({rd_valid, rd_err, rd_data} !== '0) begin
      n_err++; $display("FAIL rstfull_state got v=%b e=%b d=%h want zero", rd_valid, rd_err, rd_data);
    end
    rst = 1'b0; rd_req = 2'b01; rd_addr[0 +: AW] = 32'd5;
    adv();
    n_vec++;
    if (rd_data[0 +: DW] !== 32'h13) begin
      n_err++; $display("FAIL mem5_after_rst got %h want 00000013", rd_data[0 +: DW]);
    end
    rd_req = '0; rd_ack = '1;
    adv();
    rd_ack = '0;
  endtask

  task automatic test_stream();
    int run = 0;
    for (int k = 0; k < 16; k++) begin
      rd_req = 2'b01; rd_ack = 2'b01; rd_addr[0 +: AW] = AW'(k);
      #1;
      n_vec++;
      if (rd_gnt[0] !== 1'b1) begin n_err++; $display("FAIL stream_gnt k=%0d got %b want 1", k, rd_gnt[0]); end
      adv();
      if (rd_valid[0] === 1'b1) run++;
      n_vec++;
      if (rd_data[0 +: DW] !== m_mem[k]) begin
        n_err++; $display("FAIL stream_data k=%0d got %h want %h", k, rd_data[0 +: DW], m_mem[k]);
      end
    end
    n_vec++;
    if (run != 16) begin n_err++; $display("FAIL stream_run got %0d want 16", run); end
    rd_req = '0;
    adv();
    rd_ack = '0;
  endtask

  task automatic test_random();
    logic [NR-1:0] g;
    for (int c = 0; c < 400; c++) begin
      rst     = ($urandom_range(49, 0) == 0);
      wr_en   = !rst && ($urandom_range(4, 0) == 0);
      wr_addr = ($urandom_range(7, 0) == 0) ? $urandom : AW'($urandom_range(31, 0));
      wr_data = $urandom;
      rd_req  = NR'($urandom);
      rd_ack  = NR'($urandom);
      for (int p = 0; p < NR; p++)
        rd_addr[p*AW +: AW] = ($urandom_range(9, 0) == 0) ? $urandom : AW'($urandom_range(31, 0));
      #1;
      g = model_gnt();
      n_vec++;
      if (rd_gnt !== g) begin n_err++; $display("FAIL rand_gnt c=%0d got %b want %b", c, rd_gnt, g); end
      adv();
      n_vec++;
      if ({rd_valid, rd_err, wr_err, rd_data} !== {m_vld, m_err, m_wr_err, m_data}) begin
        n_err++; $display("FAIL rand_state c=%0d got %h want %h", c,
                          {rd_valid, rd_err, wr_err, rd_data}, {m_vld, m_err, m_wr_err, m_data});
      end
    end
    rst = 1'b0; wr_en = 1'b0; rd_req = '0; rd_ack = '0;
  endtask

  initial begin
    test_reset();
    test_preload();
    test_read_range();
    test_backpressure();
    test_wr_collision();
    test_reset_full();
    test_stream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
